// File: rtl/tsu_pkg.sv
// Shared time-value types and helpers for the tsu timestamp path.
package tsu_pkg;

  localparam int TS_BITS   = 64;
  localparam int FRAC_BITS = 16;

  typedef logic [TS_BITS-1:0] ts_t;

  // Whole picoseconds to fixed-point time, with FRAC_BITS fractional bits.
  function automatic ts_t ps_to_ts(input int ps);
    return ts_t'(ps) << FRAC_BITS;
  endfunction

endpackage

// File: rtl/tsu_ts_fifo.sv
// Synchronous FIFO with a registered head. Push and pop in the same cycle
// are both honoured. A push while full without a pop is reported on drop.
module tsu_ts_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     dout_v,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CW-1:0] cnt_q;
  logic          empty, full, do_pop, do_push;
  logic [W-1:0]  head_nx;

  // Handshake qualification and the value the head register takes next.
  always_comb begin
    empty     = (cnt_q == '0);
    full      = (cnt_q == CW'(DEPTH));
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    drop      = push && full && !do_pop;
    rd_ptr_nx = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    head_nx   = dout;
    // The pushed entry becomes head only when nothing older survives this edge.
    if (do_push && (empty || (do_pop && cnt_q == CW'(1))))
      head_nx = din;
    else if (do_pop && cnt_q > CW'(1))
      head_nx = mem[rd_ptr_nx];
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nx;
      dout   <= head_nx;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the array is not reset; the pointers and count define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout_v = !empty;
  assign cnt    = cnt_q;

endmodule

// File: rtl/tsu_ts_stamp.sv
// Converts tsu phase measurements into absolute 1588 timestamps of the
// foreign-clock marker edge and queues them for the PTP consumer.
module tsu_ts_stamp #(
  parameter int RAT_PREC_BITS = 32,
  parameter int SCALE_BITS    = 32,
  parameter int TS_BITS       = tsu_pkg::TS_BITS,
  parameter int FIFO_DEPTH    = 4,
  parameter int DROP_BITS     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TS_BITS-1:0]            i_time,
  input  logic [RAT_PREC_BITS-1:0]      i_phase,
  input  logic                          i_phase_v,
  input  logic [SCALE_BITS-1:0]         i_scale,
  input  logic [TS_BITS-1:0]            i_adj,
  input  logic                          i_clr_ovf,
  output logic [TS_BITS-1:0]            o_ts,
  output logic                          o_ts_v,
  input  logic                          i_ts_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   o_cnt,
  output logic                          o_ovf,
  output logic [DROP_BITS-1:0]          o_drop_cnt
);

  localparam int PROD_BITS = RAT_PREC_BITS + SCALE_BITS;

  logic                 v1, v2;
  logic [TS_BITS-1:0]   t_cap, ts;
  logic [PROD_BITS-1:0] prod;
  logic                 drop;

  // Valid pipeline; only the valids are flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= i_phase_v;
      v2 <= v1;
    end
  end

  // Datapath: capture time and full-width product, then subtract (wrapping).
  // NOTE: datapath registers carry no reset; they are qualified by v1/v2.
  always_ff @(posedge clk) begin
    t_cap <= i_time;
    prod  <= PROD_BITS'(i_phase) * PROD_BITS'(i_scale);
    ts    <= t_cap - TS_BITS'(prod) - i_adj;
  end

  tsu_ts_fifo #(
    .W     (TS_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (v2),
    .din    (ts),
    .pop    (i_ts_rdy),
    .dout   (o_ts),
    .dout_v (o_ts_v),
    .cnt    (o_cnt),
    .drop   (drop)
  );

  // Sticky overflow flag and saturating drop count; a drop beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ovf      <= 1'b0;
      o_drop_cnt <= '0;
    end else if (drop) begin
      o_ovf <= 1'b1;
      if (i_clr_ovf)
        o_drop_cnt <= DROP_BITS'(1);
      else if (o_drop_cnt != '1)
        o_drop_cnt <= o_drop_cnt + DROP_BITS'(1);
    end else if (i_clr_ovf) begin
      o_ovf      <= 1'b0;
      o_drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_tsu_ts_stamp.sv
// Directed bench for tsu_ts_stamp: conversion, wrap, overflow, drop
// saturation, simultaneous push/pop when full, and reset flushing.
module tb_tsu_ts_stamp;
  import tsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_time;
  logic [31:0] i_phase;
  logic        i_phase_v;
  logic [31:0] i_scale;
  logic [63:0] i_adj;
  logic        i_clr_ovf;
  logic [63:0] o_ts;
  logic        o_ts_v;
  logic        i_ts_rdy;
  logic [2:0]  o_cnt;
  logic        o_ovf;
  logic [7:0]  o_drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  tsu_ts_stamp dut (
    .clk        (clk),
    .rst        (rst),
    .i_time     (i_time),
    .i_phase    (i_phase),
    .i_phase_v  (i_phase_v),
    .i_scale    (i_scale),
    .i_adj      (i_adj),
    .i_clr_ovf  (i_clr_ovf),
    .o_ts       (o_ts),
    .o_ts_v     (o_ts_v),
    .i_ts_rdy   (i_ts_rdy),
    .o_cnt      (o_cnt),
    .o_ovf      (o_ovf),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset, with a phase pulse held during reset that must be ignored.
    rst = 1'b1; i_time = ps_to_ts(5000); i_phase = 32'd7; i_phase_v = 1'b1;
    i_scale = 32'h0001_0000; i_adj = '0; i_clr_ovf = 1'b0; i_ts_rdy = 1'b0;
    step(); step();
    check("rst_ts_v", o_ts_v, 0);
    check("rst_cnt", o_cnt, 0);
    check("rst_ovf", o_ovf, 0);
    check("rst_drop", o_drop_cnt, 0);
    check("rst_ts", o_ts, 0);
    rst = 1'b0; i_phase_v = 1'b0;
    step(); step(); step(); step();
    check("rst_pulse_ignored", o_cnt, 0);

    // Basic conversion: 1_000_000 ps - 500 * 1.0 ps.
    i_ts_rdy = 1'b1; i_time = ps_to_ts(1_000_000); i_phase = 32'd500; i_phase_v = 1'b1;
    step(); i_phase_v = 1'b0;
    step();
    check("basic_latency_n2", o_ts_v, 0);
    step();
    check("basic_v", o_ts_v, 1);
    check("basic_ts", o_ts, ps_to_ts(999_500));
    check("basic_cnt", o_cnt, 1);
    step();
    check("basic_popped", o_ts_v, 0);
    check("empty_hold_ts", o_ts, ps_to_ts(999_500));

    // Fractional scale and adjust: 100 - 3*0.5 - 10 = 88.5 ps.
    i_scale = 32'h0000_8000; i_phase = 32'd3; i_adj = ps_to_ts(10); i_time = ps_to_ts(100);
    i_phase_v = 1'b1;
    step(); i_phase_v = 1'b0;
    step(); step();
    check("frac_ts", o_ts, 64'h0000_0000_0058_8000);

    // Wrap below zero.
    i_scale = 32'h0001_0000; i_phase = 32'd1; i_adj = '0; i_time = '0;
    i_phase_v = 1'b1;
    step(); i_phase_v = 1'b0;
    step(); step();
    check("wrap_ts", o_ts, 64'hFFFF_FFFF_FFFF_0000);
    check("wrap_no_ovf", o_ovf, 0);
    step();

    // Overflow: six back-to-back pulses into a depth-4 queue, no reads.
    i_ts_rdy = 1'b0; i_phase = 32'd0;
    for (int k = 1; k <= 6; k++) begin
      i_time = ps_to_ts(k * 1000); i_phase_v = 1'b1;
      step();
    end
    i_phase_v = 1'b0;
    step(); step(); step();
    check("ovf_cnt", o_cnt, 4);
    check("ovf_flag", o_ovf, 1);
    check("ovf_drop_cnt", o_drop_cnt, 2);
    i_ts_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf_order_%0d", k), o_ts, ps_to_ts(k * 1000));
      step();
    end
    check("ovf_drained_v", o_ts_v, 0);
    check("ovf_drained_cnt", o_cnt, 0);
    i_ts_rdy = 1'b0;

    // Clear the sticky flag and counter.
    i_clr_ovf = 1'b1;
    step(); i_clr_ovf = 1'b0;
    check("clr_ovf", o_ovf, 0);
    check("clr_drop", o_drop_cnt, 0);

    // Full queue with push and pop in the same cycle: no drop.
    for (int k = 11; k <= 14; k++) begin
      i_time = ps_to_ts(k * 1000); i_phase_v = 1'b1;
      step();
    end
    i_phase_v = 1'b0;
    step(); step(); step();
    check("full_cnt", o_cnt, 4);
    i_time = ps_to_ts(15_000); i_phase_v = 1'b1;
    step(); i_phase_v = 1'b0;
    step(); i_ts_rdy = 1'b1;
    step(); i_ts_rdy = 1'b0;
    check("pp_cnt", o_cnt, 4);
    check("pp_ovf", o_ovf, 0);
    check("pp_drop", o_drop_cnt, 0);
    check("pp_head", o_ts, ps_to_ts(12_000));
    step();
    check("stall_hold", o_ts, ps_to_ts(12_000));
    i_ts_rdy = 1'b1;
    for (int k = 12; k <= 15; k++) begin
      check($sformatf("pp_order_%0d", k), o_ts, ps_to_ts(k * 1000));
      step();
    end
    check("pp_drained", o_cnt, 0);
    i_ts_rdy = 1'b0;

    // Drop and clear in the same cycle: drop wins, count restarts at 1.
    for (int k = 21; k <= 25; k++) begin
      i_time = ps_to_ts(k * 1000); i_phase_v = 1'b1;
      step();
    end
    i_phase_v = 1'b0;
    step(); step(); step();
    check("pre_clr_drop", o_drop_cnt, 1);
    i_time = ps_to_ts(26_000); i_phase_v = 1'b1;
    step(); i_phase_v = 1'b0;
    step(); i_clr_ovf = 1'b1;
    step(); i_clr_ovf = 1'b0;
    check("clr_vs_drop_ovf", o_ovf, 1);
    check("clr_vs_drop_cnt", o_drop_cnt, 1);

    // Drop counter saturation with a continuously full queue.
    i_time = ps_to_ts(99_000); i_phase_v = 1'b1;
    for (int k = 0; k < 300; k++) step();
    i_phase_v = 1'b0;
    step(); step(); step();
    check("sat_drop_cnt", o_drop_cnt, 8'hFF);
    check("sat_cnt", o_cnt, 4);
    check("sat_head_untouched", o_ts, ps_to_ts(21_000));

    // Reset mid-flight: pulse at N, reset during N+1.
    i_ts_rdy = 1'b1;
    step(); step(); step(); step(); step();
    i_ts_rdy = 1'b0;
    i_time = ps_to_ts(77_000); i_phase_v = 1'b1;
    step(); i_phase_v = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    check("mid_rst_ts_v", o_ts_v, 0);
    check("mid_rst_ts", o_ts, 0);
    check("mid_rst_ovf", o_ovf, 0);
    check("mid_rst_drop", o_drop_cnt, 0);
    step(); step(); step(); step();
    check("mid_rst_no_entry_v", o_ts_v, 0);
    check("mid_rst_no_entry_cnt", o_cnt, 0);
    check("mid_rst_ts_later", o_ts, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tsu_ts_stamp.md
Name: tsu_ts_stamp

Overview:
Downstream consumer of the tsu phase output (o_phase/o_phase_v).
- Converts each phase measurement into an absolute 1588 timestamp of the foreign-clock marker edge, in fixed-point picoseconds.
- Method: capture the free-running 1588 time at the valid pulse, subtract the scaled phase and a software latency/offset adjust.
- Timestamps queue in a small FIFO read by the PTP logic through a valid/ready handshake.

Parameters:
RAT_PREC_BITS, 32, width of i_phase (matches tsu).
SCALE_BITS, 32, width of i_scale; unsigned, units 2^-FRAC_BITS ps per phase LSB.
FRAC_BITS, 16, fractional bits of all time values.
TS_BITS, 64, width of time values (TS_BITS-FRAC_BITS integer ps).
FIFO_DEPTH, 4, timestamp queue entries (power of 2, >=2).
DROP_BITS, 8, width of the saturating drop counter.

Ports:
clk  in  1  1588 clock.
rst  in  1  Synchronous, active-high reset.
i_time  in  TS_BITS  Current 1588 time at this clk edge, fixed-point ps.
i_phase  in  RAT_PREC_BITS  Phase from tsu o_phase.
i_phase_v  in  1  One-cycle valid from tsu o_phase_v.
i_scale  in  SCALE_BITS  ps per phase LSB, Q.FRAC_BITS; static while operating.
i_adj  in  TS_BITS  Two's-complement constant subtracted (pipeline latency minus offset); static.
i_clr_ovf  in  1  Clears o_ovf and o_drop_cnt.
o_ts  out  TS_BITS  Timestamp at FIFO head.
o_ts_v  out  1  Head valid.
i_ts_rdy  in  1  Consumer ready; pop when o_ts_v & i_ts_rdy.
o_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
o_ovf  out  1  Sticky: a timestamp was dropped.
o_drop_cnt  out  DROP_BITS  Dropped timestamps, saturating.

Behaviour:
- Reset (rst=1 at clk edge): pipeline valids=0, FIFO empty; o_ts_v=0, o_cnt=0, o_ovf=0, o_drop_cnt=0, o_ts=0.
- Reset mid-operation flushes all in-flight stages and queue entries. No output is produced for any i_phase_v seen in the reset cycle.
- S1, edge after i_phase_v at cycle N:
  - t_cap <= i_time.
  - prod <= i_phase*i_scale, full RAT_PREC_BITS+SCALE_BITS product.
  - v1 <= 1.
- S2, cycle N+2: ts <= t_cap - prod[TS_BITS-1:0] - i_adj, modulo 2^TS_BITS (wraps, no saturation); v2 <= v1.
  - Product bits above TS_BITS are discarded.
- FIFO push when v2=1; entry visible on o_ts/o_ts_v at N+3 if the queue was empty.
- Throughput: one i_phase_v per cycle accepted; back-to-back inputs give back-to-back pushes.
- o_ts is registered from the head entry. Pop and push in the same cycle are both honoured; o_cnt unchanged.
- Full, with push and no pop: new entry dropped, queue contents untouched, o_ovf<=1, o_drop_cnt+=1 (saturates at all-ones).
- Full, with push and pop in the same cycle: push accepted, no drop.
- Empty with i_ts_rdy=1: no effect, o_ts holds its last value.
- i_clr_ovf and a drop in the same cycle: the drop wins, giving o_ovf=1 and o_drop_cnt=1.
- o_ts stable while o_ts_v=1 and i_ts_rdy=0.

Decomposition:
- Package tsu_pkg: ts_t typedef (TS_BITS logic), FRAC_BITS constant, helper function ps_to_ts(int) returning the value shifted left by FRAC_BITS.
- One sub-module tsu_ts_fifo: synchronous FIFO with registered head, full/empty/count, same-cycle push+pop.
- Multiply and subtract stages live in tsu_ts_stamp.

Test Plan:
- Basic conversion: i_scale=1<<16, i_adj=0, i_time=ps_to_ts(1_000_000), i_phase=500, pulse at N, i_ts_rdy=1 -> o_ts=ps_to_ts(999_500) with o_ts_v=1 at N+3, o_cnt=1.
- Fractional scale and adjust: i_scale=0x8000 (0.5ps), i_phase=3, i_adj=ps_to_ts(10), i_time=ps_to_ts(100) -> o_ts=ps_to_ts(88.5), i.e. 0x0058_8000.
- Wrap: i_time=0, i_phase=1, i_scale=1<<16, i_adj=0 -> o_ts=2^64-65536, no error flag.
- Overflow: i_ts_rdy=0, 6 consecutive pulses at depth 4 -> o_cnt=4, o_ovf=1, o_drop_cnt=2, and the first 4 timestamps pop in order.
- Full with simultaneous push and pop: queue full, i_ts_rdy=1 on the push cycle -> o_cnt stays 4, o_ovf=0.
- Reset mid-flight: pulse at N, rst=1 at N+1 -> no entry ever appears, all outputs 0 from N+2.
